pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Hazard/pipeline control unit. It consumes stall and redirect requests from the ID, EXE and MEM stages and from the instruction/data bus handshakes, including the load-use request from the forwarding unit.
- It drives per-register stall and flush vectors to the 5-stage RV32 pipeline.
- It owns the PC-redirect handshake to fetch, and discards the fetch response that was in flight when a redirect was taken.
- It keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
PC_WIDTH, 32, width of redirect/branch/trap addresses
CNT_WIDTH, 32, width of stall-cycle counter

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
load_use_stall_i  in  1  load-use hazard from forwarding unit
exe_busy_i  in  1  multi-cycle EXE op (mul/div) not finished
if_req_i  in  1  fetch request outstanding
if_ack_i  in  1  fetch response valid
mem_req_i  in  1  data access in MEM stage
mem_ack_i  in  1  data access complete
branch_taken_i  in  1  EXE resolved taken branch/jump
branch_pc_i  in  PC_WIDTH  branch target
trap_i  in  1  MEM-stage exception/ecall
trap_pc_i  in  PC_WIDTH  trap vector
redirect_ready_i  in  1  fetch accepted redirect
stall_o  out  5  hold: [0]PC [1]IF/ID [2]ID/EXE [3]EXE/MEM [4]MEM/WB
flush_o  out  5  bubble-insert, same bit map
redirect_valid_o  out  1  redirect request to fetch
redirect_pc_o  out  PC_WIDTH  redirect target
if_drop_o  out  1  discard current fetch response
stall_cnt_o  out  CNT_WIDTH  cycles with stall_o[0]=1

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous and active-low. Sampled at posedge clk while rst_n=0, all registers reset. Reset values: redirect_valid_o=0, redirect_pc_o=0, drop flag=0, stall_cnt_o=0, FSM=RUN.
- stall_o/flush_o: combinational, same-cycle from inputs and state. They are also forced to 0 while rst_n=0.
- Stall causes, highest priority first; exactly one cause applies per cycle:
  1. dmem_wait = mem_req_i & ~mem_ack_i -> stall=5'b01111, flush=5'b10000.
  2. exe_busy_i -> stall=5'b00111, flush=5'b01000.
  3. load_use_stall_i -> stall=5'b00011, flush=5'b00100.
  4. REDIR state -> stall=5'b00001, flush=5'b00010.
  5. ifetch_wait = if_req_i & ~if_ack_i -> stall=5'b00001, flush=5'b00010.
- Trap (trap_i=1): overrides every cause. Forces stall=0 and flush=5'b01110. Next posedge: redirect_pc_o<=trap_pc_i, redirect_valid_o<=1, FSM->REDIR.
- Branch (branch_taken_i=1 and neither dmem_wait nor exe_busy_i nor trap_i):
  - flush |= 5'b00110; stall[2:1] cleared. stall[0] is kept only from ifetch_wait.
  - Next posedge: redirect_pc_o<=branch_pc_i, redirect_valid_o<=1, FSM->REDIR.
  - A branch blocked by dmem_wait/exe_busy_i is not latched. EXE is frozen, so the branch is re-presented and taken once the stall clears.
- FSM:
  - RUN -> REDIR on accepted branch or trap.
  - REDIR -> RUN on redirect_ready_i=1. redirect_valid_o drops next cycle.
  - A trap while in REDIR overwrites redirect_pc_o and stays in REDIR.
  - redirect_valid_o and redirect_pc_o are stable while valid & ~ready.
- Drop flag:
  - Set at the posedge that enters REDIR if ifetch_wait holds that cycle.
  - While set, if_drop_o = if_ack_i. The flag clears on the posedge where if_ack_i=1.
  - Set and clear in the same cycle: clear wins, and if_drop_o=1 that cycle.
- stall_cnt_o: +1 each cycle stall_o[0]=1; saturates at all-ones, no wrap.
- Reset mid-REDIR or with the drop flag pending: everything returns to reset values next cycle, with no residual drop.

Test Plan:
- Load-use: load_use_stall_i=1 for 1 cycle -> stall_o=00011, flush_o=00100 that cycle; stall_cnt_o 0->1.
- Branch with fetch idle: branch_taken_i=1, branch_pc_i=32'h0000_0040 -> flush_o=00110 that cycle. Next cycle redirect_valid_o=1, pc=0x40; it holds 3 cycles with redirect_ready_i=0 (stall_o=00001, flush_o=00010), then ready=1 -> RUN.
- Branch with fetch outstanding: if_req_i=1, if_ack_i=0, branch taken -> 2 cycles later if_ack_i=1 -> if_drop_o=1 for exactly that cycle; a following ack gives if_drop_o=0.
- Priority: mem_req_i=1, mem_ack_i=0, exe_busy_i=1, branch_taken_i=1 -> stall_o=01111, flush_o=10000, no redirect. Then mem_ack_i=1 and exe_busy_i=0 -> branch taken.
- Trap overrides a pending branch redirect: in REDIR (pc=0x40), trap_i=1, trap_pc_i=0x100 -> flush_o=01110. Next cycle redirect_pc_o=0x100, valid stays 1.
- Reset: drive rst_n=0 for 1 cycle during REDIR with the drop flag set -> all outputs 0 next cycle. Saturation: preload to all-ones minus 1, stall 3 cycles -> stall_cnt_o holds at all-ones.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Hazard-control bundle between the pipeline and pipeline_ctrl.
// slave = the controller side, master = the pipeline/fetch side.
interface pipeline_ctrl_if #(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 32
);
    logic                 load_use_stall_i;
    logic                 exe_busy_i;
    logic                 if_req_i;
    logic                 if_ack_i;
    logic                 mem_req_i;
    logic                 mem_ack_i;
    logic                 branch_taken_i;
    logic [PC_WIDTH-1:0]  branch_pc_i;
    logic                 trap_i;
    logic [PC_WIDTH-1:0]  trap_pc_i;
    logic                 redirect_ready_i;
    logic [4:0]           stall_o;
    logic [4:0]           flush_o;
    logic                 redirect_valid_o;
    logic [PC_WIDTH-1:0]  redirect_pc_o;
    logic                 if_drop_o;
    logic [CNT_WIDTH-1:0] stall_cnt_o;

    modport slave (
        input  load_use_stall_i, exe_busy_i, if_req_i, if_ack_i,
        input  mem_req_i, mem_ack_i, branch_taken_i, branch_pc_i,
        input  trap_i, trap_pc_i, redirect_ready_i,
        output stall_o, flush_o, redirect_valid_o, redirect_pc_o,
        output if_drop_o, stall_cnt_o
    );

    modport master (
        output load_use_stall_i, exe_busy_i, if_req_i, if_ack_i,
        output mem_req_i, mem_ack_i, branch_taken_i, branch_pc_i,
        output trap_i, trap_pc_i, redirect_ready_i,
        input  stall_o, flush_o, redirect_valid_o, redirect_pc_o,
        input  if_drop_o, stall_cnt_o
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard/pipeline control: stall/flush vectors, PC redirect handshake,
// stale-fetch drop and saturating stall-cycle counter.
module pipeline_ctrl #(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    pipeline_ctrl_if.slave bus
);
    typedef enum logic {RUN = 1'b0, REDIR = 1'b1} state_e;

    state_e               state_q, state_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic                 drop_q, drop_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic       dmem_wait;
    logic       ifetch_wait;
    logic       br_take;
    logic       enter_redir;
    logic [4:0] stall;
    logic [4:0] flush;

    assign dmem_wait   = bus.mem_req_i & ~bus.mem_ack_i;
    assign ifetch_wait = bus.if_req_i & ~bus.if_ack_i;
    // EXE holds only bubbles while redirecting, so branches count in RUN
    assign br_take     = (state_q == RUN) & bus.branch_taken_i
                       & ~dmem_wait & ~bus.exe_busy_i & ~bus.trap_i;
    assign enter_redir = (state_q == RUN) & (bus.trap_i | br_take);

    // State register plus redirect target, drop flag and counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= '0;
            drop_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: trap always (re)targets, branch only from RUN
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (bus.trap_i) begin
            state_d = REDIR;
            pc_d    = bus.trap_pc_i;
        end else if (br_take) begin
            state_d = REDIR;
            pc_d    = bus.branch_pc_i;
        end else if (state_q == REDIR && bus.redirect_ready_i) begin
            state_d = RUN;
        end
    end

    // Drop flag and saturating stall counter; ack-clear wins over set
    always_comb begin
        drop_d = drop_q;
        if (enter_redir && ifetch_wait) begin
            drop_d = 1'b1;
        end
        if (bus.if_ack_i) begin
            drop_d = 1'b0;
        end
        cnt_d = cnt_q;
        if (stall[0] && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Outputs: prioritised stall causes, branch/trap flush override
    always_comb begin
        stall = 5'b00000;
        flush = 5'b00000;
        if (!rst_n) begin
            stall = 5'b00000;
            flush = 5'b00000;
        end else if (bus.trap_i) begin
            flush = 5'b01110;
        end else if (dmem_wait) begin
            stall = 5'b01111;
            flush = 5'b10000;
        end else if (bus.exe_busy_i) begin
            stall = 5'b00111;
            flush = 5'b01000;
        end else if (br_take) begin
            stall = {4'b0000, ifetch_wait};
            flush = 5'b00110;
        end else if (bus.load_use_stall_i) begin
            stall = 5'b00011;
            flush = 5'b00100;
        end else if (state_q == REDIR || ifetch_wait) begin
            stall = 5'b00001;
            flush = 5'b00010;
        end
    end

    assign bus.stall_o          = stall;
    assign bus.flush_o          = flush;
    assign bus.redirect_valid_o = (state_q == REDIR);
    assign bus.redirect_pc_o    = pc_q;
    assign bus.if_drop_o        = drop_q & bus.if_ack_i;
    assign bus.stall_cnt_o      = cnt_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: rule-level model checked
// every cycle plus literal expectations for the directed scenarios.
module tb_pipeline_ctrl;
    localparam int PW = 32;
    localparam int CW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errs = 0;

    always #5 clk = ~clk;

    pipeline_ctrl_if #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) bus ();

    pipeline_ctrl #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [4:0] st_tab [0:5] = '{5'b01111, 5'b00111, 5'b00011,
                                 5'b00001, 5'b00001, 5'b00000};
    logic [4:0] fl_tab [0:5] = '{5'b10000, 5'b01000, 5'b00100,
                                 5'b00010, 5'b00010, 5'b00000};

    bit          m_redir = 0, n_redir = 0;
    bit [PW-1:0] m_pc = '0, n_pc = '0;
    bit          m_drop = 0, n_drop = 0;
    int          m_cnt = 0, n_cnt = 0;
    int          cnt_max = (1 << CW) - 1;

    always @(negedge clk) begin
        bit dw, ew, lu, fw, bt;
        int c;
        logic [4:0] es, ef;
        dw = bus.mem_req_i && !bus.mem_ack_i;
        ew = bus.exe_busy_i;
        lu = bus.load_use_stall_i;
        fw = bus.if_req_i && !bus.if_ack_i;
        c = 5;
        if (fw) c = 4;
        if (m_redir) c = 3;
        if (lu) c = 2;
        if (ew) c = 1;
        if (dw) c = 0;
        bt = !m_redir && bus.branch_taken_i && !dw && !ew && !bus.trap_i;
        if (!rst_n) begin
            es = 0; ef = 0;
        end else if (bus.trap_i) begin
            es = 0; ef = 5'b01110;
        end else if (bt) begin
            es = (st_tab[c] & 5'b11000) | {4'b0, fw};
            ef = fl_tab[c] | 5'b00110;
        end else begin
            es = st_tab[c]; ef = fl_tab[c];
        end
        check("m_stall", bus.stall_o, es);
        check("m_flush", bus.flush_o, ef);
        check("m_valid", bus.redirect_valid_o, m_redir);
        check("m_pc", bus.redirect_pc_o, m_pc);
        check("m_drop", bus.if_drop_o, m_drop && bus.if_ack_i);
        check("m_cnt", bus.stall_cnt_o, m_cnt);
        n_redir = m_redir; n_pc = m_pc; n_drop = m_drop; n_cnt = m_cnt;
        if (bus.trap_i) begin
            n_redir = 1; n_pc = bus.trap_pc_i;
        end else if (bt) begin
            n_redir = 1; n_pc = bus.branch_pc_i;
        end else if (m_redir && bus.redirect_ready_i) begin
            n_redir = 0;
        end
        if (!m_redir && (bus.trap_i || bt) && fw) n_drop = 1;
        if (bus.if_ack_i) n_drop = 0;
        if (es[0] && m_cnt < cnt_max) n_cnt = m_cnt + 1;
        if (!rst_n) begin
            n_redir = 0; n_pc = '0; n_drop = 0; n_cnt = 0;
        end
    end

    always @(posedge clk) begin
        m_redir <= n_redir;
        m_pc    <= n_pc;
        m_drop  <= n_drop;
        m_cnt   <= n_cnt;
    end

    // ---------------- stimulus ----------------
    task automatic set_idle();
        bus.load_use_stall_i = 0; bus.exe_busy_i = 0;
        bus.if_req_i = 0;         bus.if_ack_i = 0;
        bus.mem_req_i = 0;        bus.mem_ack_i = 0;
        bus.branch_taken_i = 0;   bus.branch_pc_i = '0;
        bus.trap_i = 0;           bus.trap_pc_i = '0;
        bus.redirect_ready_i = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        set_idle();
        rst_n = 0;
        repeat (2) step();
        rst_n = 1;
        mid();
        check("rst_stall", bus.stall_o, 0);
        check("rst_flush", bus.flush_o, 0);
        check("rst_valid", bus.redirect_valid_o, 0);
        check("rst_pc", bus.redirect_pc_o, 0);
        check("rst_cnt", bus.stall_cnt_o, 0);
        check("rst_drop", bus.if_drop_o, 0);
        step();

        // load-use
        bus.load_use_stall_i = 1;
        mid();
        check("lu_stall", bus.stall_o, 5'b00011);
        check("lu_flush", bus.flush_o, 5'b00100);
        check("lu_cnt0", bus.stall_cnt_o, 0);
        step(); set_idle();
        mid();
        check("lu_cnt1", bus.stall_cnt_o, 1);
        step();

        // branch, fetch idle
        bus.branch_taken_i = 1; bus.branch_pc_i = 32'h40;
        mid();
        check("br_flush", bus.flush_o, 5'b00110);
        check("br_stall", bus.stall_o, 0);
        check("br_valid0", bus.redirect_valid_o, 0);
        step(); set_idle();
        repeat (3) begin
            mid();
            check("rd_valid", bus.redirect_valid_o, 1);
            check("rd_pc", bus.redirect_pc_o, 32'h40);
            check("rd_stall", bus.stall_o, 5'b00001);
            check("rd_flush", bus.flush_o, 5'b00010);
            step();
        end
        bus.redirect_ready_i = 1;
        mid();
        check("rd_valid_acc", bus.redirect_valid_o, 1);
        step(); set_idle();
        mid();
        check("run_valid", bus.redirect_valid_o, 0);
        check("run_stall", bus.stall_o, 0);
        check("run_cnt", bus.stall_cnt_o, 5);
        step();

        // branch with fetch outstanding
        bus.if_req_i = 1; bus.branch_taken_i = 1; bus.branch_pc_i = 32'h80;
        mid();
        check("bf_stall", bus.stall_o, 5'b00001);
        check("bf_flush", bus.flush_o, 5'b00110);
        step();
        bus.branch_taken_i = 0;
        mid();
        check("bf_drop0", bus.if_drop_o, 0);
        check("bf_valid", bus.redirect_valid_o, 1);
        step();
        bus.if_ack_i = 1;
        mid();
        check("bf_drop1", bus.if_drop_o, 1);
        step();
        bus.redirect_ready_i = 1;
        mid();
        check("bf_drop2", bus.if_drop_o, 0);
        step(); set_idle();
        mid();
        check("bf_cnt", bus.stall_cnt_o, 9);
        step();

        // priority: dmem wait blocks branch
        bus.mem_req_i = 1; bus.exe_busy_i = 1;
        bus.branch_taken_i = 1; bus.branch_pc_i = 32'hC0;
        mid();
        check("pr_stall", bus.stall_o, 5'b01111);
        check("pr_flush", bus.flush_o, 5'b10000);
        step();
        bus.mem_ack_i = 1; bus.exe_busy_i = 0;
        mid();
        check("pr_valid0", bus.redirect_valid_o, 0);
        check("pr_flush2", bus.flush_o, 5'b00110);
        step(); set_idle();
        bus.redirect_ready_i = 1;
        mid();
        check("pr_valid1", bus.redirect_valid_o, 1);
        check("pr_pc", bus.redirect_pc_o, 32'hC0);
        step(); set_idle();
        step();

        // trap overrides pending redirect
        bus.branch_taken_i = 1; bus.branch_pc_i = 32'h40;
        step(); set_idle();
        bus.trap_i = 1; bus.trap_pc_i = 32'h100;
        mid();
        check("tr_pc_old", bus.redirect_pc_o, 32'h40);
        check("tr_flush", bus.flush_o, 5'b01110);
        check("tr_stall", bus.stall_o, 0);
        step(); set_idle();
        bus.redirect_ready_i = 1;
        mid();
        check("tr_valid", bus.redirect_valid_o, 1);
        check("tr_pc", bus.redirect_pc_o, 32'h100);
        step(); set_idle();

        // reset mid-REDIR with drop pending
        bus.if_req_i = 1; bus.branch_taken_i = 1; bus.branch_pc_i = 32'h200;
        step();
        bus.branch_taken_i = 0;
        mid();
        check("rr_valid", bus.redirect_valid_o, 1);
        step();
        rst_n = 0;
        mid();
        check("rr_stall", bus.stall_o, 0);
        check("rr_flush", bus.flush_o, 0);
        step();
        rst_n = 1; set_idle(); bus.if_ack_i = 1;
        mid();
        check("rr_valid0", bus.redirect_valid_o, 0);
        check("rr_pc0", bus.redirect_pc_o, 0);
        check("rr_cnt0", bus.stall_cnt_o, 0);
        check("rr_drop0", bus.if_drop_o, 0);
        step(); set_idle();

        // mixed vectors, checked by the model only
        for (int i = 0; i < 60; i++) begin
            bus.load_use_stall_i = ($urandom_range(0, 3) == 0);
            bus.exe_busy_i       = ($urandom_range(0, 5) == 0);
            bus.if_req_i         = $urandom_range(0, 1);
            bus.if_ack_i         = $urandom_range(0, 1);
            bus.mem_req_i        = ($urandom_range(0, 3) == 0);
            bus.mem_ack_i        = $urandom_range(0, 1);
            bus.branch_taken_i   = ($urandom_range(0, 3) == 0);
            bus.branch_pc_i      = $urandom;
            bus.trap_i           = ($urandom_range(0, 9) == 0);
            bus.trap_pc_i        = $urandom;
            bus.redirect_ready_i = $urandom_range(0, 1);
            step();
        end
        set_idle();

        // saturation
        rst_n = 0;
        step();
        rst_n = 1;
        bus.exe_busy_i = 1;
        repeat (30) step();
        mid();
        check("sat_30", bus.stall_cnt_o, 30);
        step();
        repeat (3) begin
            mid();
            check("sat_max", bus.stall_cnt_o, 31);
            step();
        end
        set_idle();
        step();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
